hub75_fb_scheduler: RTL and testbench

//  Owns the double-buffered framebuffer behind the HUB75 panel driver. Shares one single-port RAM per

---
 rtl/hub75_pkg.sv | 17 +
 rtl/hub75_fb_scheduler.sv | 170 +++++++++++++++++
 tb/tb_hub75_fb_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 framebuffer scheduler.
package hub75_pkg;

   // Scheduler phases: normal operation, waiting for a frame boundary to swap,
   // and zero-filling the freshly exposed back bank.
   typedef enum logic [1:0] {
      FB_RUN       = 2'd0,
      FB_SWAP_WAIT = 2'd1,
      FB_CLEAR     = 2'd2
   } fb_sched_state_t;

   // Address width of one segment RAM bank.
   function automatic int fb_addr_w(input int h, input int v, input int seg);
      return $clog2(h * v / seg);
   endfunction

endpackage

// File: rtl/hub75_fb_scheduler.sv
// Double-buffered framebuffer scheduler for a HUB75 panel driver.
// One single-port RAM per segment holds both banks ({bank, addr}). Display
// reads hit the front bank, host writes and the post-swap clear hit the back
// bank. Bank swaps are deferred to a frame boundary so the panel never tears.
//
// Handshake: a host write transfers on a cycle where i_wr_valid && o_wr_ready
// are both high at the rising clock edge. o_wr_ready depends only on the
// display read request and the scheduler state, never on i_wr_valid, and the
// host must hold its request stable until it transfers.
module hub75_fb_scheduler
   import hub75_pkg::*;
#(
   parameter int HPIXEL        = 64,
   parameter int VPIXEL        = 64,
   parameter int BPP           = 8,
   parameter int SEGMENTS      = 2,
   parameter int CLEAR_ON_SWAP = 1,
   parameter int ADDR_W        = fb_addr_w(HPIXEL, VPIXEL, SEGMENTS),
   parameter int SEG_W         = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_enable,
   input  logic                         i_disp_rd_en,
   input  logic [ADDR_W-1:0]            i_disp_rd_addr,
   input  logic                         i_disp_frame_done,
   output logic [SEGMENTS*3*BPP-1:0]    o_disp_rd_data,
   output logic                         o_disp_rd_valid,
   input  logic                         i_wr_valid,
   output logic                         o_wr_ready,
   input  logic [SEG_W-1:0]             i_wr_seg,
   input  logic [ADDR_W-1:0]            i_wr_addr,
   input  logic [3*BPP-1:0]             i_wr_data,
   output logic                         o_wr_drop,
   input  logic                         i_swap_req,
   output logic                         o_swap_pending,
   output logic                         o_front_bank,
   output logic                         o_busy_clear,
   output logic [SEGMENTS-1:0]          o_mem_en,
   output logic [SEGMENTS-1:0]          o_mem_we,
   output logic [ADDR_W:0]              o_mem_addr,
   output logic [3*BPP-1:0]             o_mem_wdata,
   input  logic [SEGMENTS*3*BPP-1:0]    i_mem_rdata,
   output logic [1:0]                   o_dbg_state
);

   localparam int DEPTH = HPIXEL * VPIXEL / SEGMENTS;

   fb_sched_state_t   state_q, state_d;
   logic              front_bank_q, front_bank_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_drop_q, wr_drop_d;
   logic              swap_pending_q, swap_pending_d;

   logic wr_fire;
   logic wr_in_range;
   logic clr_write;
   logic frame_edge;
   logic do_swap;

   // Write handshake and port-usage qualifiers.
   always_comb begin
      o_wr_ready  = rst_n && !i_disp_rd_en && (state_q == FB_RUN);
      wr_fire     = i_wr_valid && o_wr_ready;
      wr_in_range = (int'(i_wr_addr) < DEPTH) && (int'(i_wr_seg) < SEGMENTS);
      clr_write   = rst_n && (state_q == FB_CLEAR) && !i_disp_rd_en;
      frame_edge  = i_disp_frame_done || !i_enable;
   end

   // RAM port arbiter: display read wins, then the clear, then the host.
   always_comb begin
      o_mem_en    = '0;
      o_mem_we    = '0;
      o_mem_addr  = {front_bank_q, i_disp_rd_addr};
      o_mem_wdata = '0;
      if (rst_n && i_disp_rd_en) begin
         o_mem_en   = '1;
         o_mem_addr = {front_bank_q, i_disp_rd_addr};
      end else if (clr_write) begin
         o_mem_en   = '1;
         o_mem_we   = '1;
         o_mem_addr = {!front_bank_q, clr_cnt_q};
      end else if (wr_fire && wr_in_range) begin
         for (int s = 0; s < SEGMENTS; s++) begin
            o_mem_en[s] = (i_wr_seg == SEG_W'(s));
            o_mem_we[s] = (i_wr_seg == SEG_W'(s));
         end
         o_mem_addr  = {!front_bank_q, i_wr_addr};
         o_mem_wdata = i_wr_data;
      end
   end

   // Scheduler next-state: swap at frame boundaries, then optionally clear.
   always_comb begin
      state_d        = state_q;
      front_bank_d   = front_bank_q;
      clr_cnt_d      = clr_cnt_q;
      swap_pending_d = swap_pending_q;
      rd_valid_d     = i_disp_rd_en;
      wr_drop_d      = wr_fire && !wr_in_range;
      do_swap        = 1'b0;
      case (state_q)
         FB_RUN: begin
            if (i_swap_req) begin
               if (frame_edge) begin
                  do_swap = 1'b1;
               end else begin
                  state_d        = FB_SWAP_WAIT;
                  swap_pending_d = 1'b1;
               end
            end
         end
         FB_SWAP_WAIT: begin
            if (frame_edge) begin
               do_swap = 1'b1;
            end
         end
         FB_CLEAR: begin
            if (clr_write) begin
               if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                  clr_cnt_d = '0;
                  state_d   = FB_RUN;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = FB_RUN;
         end
      endcase
      if (do_swap) begin
         front_bank_d   = !front_bank_q;
         swap_pending_d = 1'b0;
         state_d        = (CLEAR_ON_SWAP != 0) ? FB_CLEAR : FB_RUN;
      end
   end

   // State registers; reset abandons any swap or clear in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= FB_RUN;
         front_bank_q   <= 1'b0;
         clr_cnt_q      <= '0;
         rd_valid_q     <= 1'b0;
         wr_drop_q      <= 1'b0;
         swap_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         front_bank_q   <= front_bank_d;
         clr_cnt_q      <= clr_cnt_d;
         rd_valid_q     <= rd_valid_d;
         wr_drop_q      <= wr_drop_d;
         swap_pending_q <= swap_pending_d;
      end
   end

   // Output mapping.
   always_comb begin
      o_disp_rd_data  = i_mem_rdata;
      o_disp_rd_valid = rd_valid_q;
      o_wr_drop       = wr_drop_q;
      o_swap_pending  = swap_pending_q;
      o_front_bank    = front_bank_q;
      o_busy_clear    = (state_q == FB_CLEAR);
      o_dbg_state     = state_q;
   end

endmodule

// File: tb/tb_hub75_fb_scheduler.sv
// Bench for hub75_fb_scheduler. Main instance uses a non-power-of-two
// segment depth (768) so out-of-range writes are expressible; a second
// instance at default geometry with CLEAR_ON_SWAP=0 covers the no-clear swap.
module tb_hub75_fb_scheduler;
  import hub75_pkg::*;

  localparam int HP    = 48;
  localparam int VP    = 32;
  localparam int SEGS  = 2;
  localparam int DEPTH = HP * VP / SEGS;
  localparam int AW    = 10;
  localparam int PW    = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nc_rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic enable, rd_en, frame_done, wr_valid, wr_seg, swap_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] wr_data;
  logic [2*PW-1:0] rd_data, mem_rdata;
  logic rd_valid, wr_ready, wr_drop, swap_pending, front_bank, busy_clear;
  logic [1:0] mem_en, mem_we, dbg_state;
  logic [AW:0] mem_addr;
  logic [PW-1:0] mem_wdata;

  hub75_fb_scheduler #(.HPIXEL(HP), .VPIXEL(VP), .BPP(8), .SEGMENTS(SEGS), .CLEAR_ON_SWAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_disp_rd_en(rd_en), .i_disp_rd_addr(rd_addr),
    .i_disp_frame_done(frame_done), .o_disp_rd_data(rd_data), .o_disp_rd_valid(rd_valid),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_seg(wr_seg), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_wr_drop(wr_drop), .i_swap_req(swap_req), .o_swap_pending(swap_pending),
    .o_front_bank(front_bank), .o_busy_clear(busy_clear), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // Segment RAMs with 1-cycle read latency.
  logic [PW-1:0] ram [SEGS][2**(AW+1)];
  always @(posedge clk) begin
    for (int s = 0; s < SEGS; s++) begin
      if (mem_en[s]) begin
        if (mem_we[s]) ram[s][mem_addr] <= mem_wdata;
        else mem_rdata[s*PW +: PW] <= ram[s][mem_addr];
      end
    end
  end

  // ---------------- second DUT: default geometry, no clear ----------------
  logic nc_enable, nc_rd_en, nc_frame_done, nc_wr_valid, nc_wr_seg, nc_swap_req;
  logic [10:0] nc_rd_addr, nc_wr_addr;
  logic [PW-1:0] nc_wr_data, nc_mem_wdata;
  logic [2*PW-1:0] nc_rd_data;
  logic [2*PW-1:0] nc_mem_rdata = '0;
  logic nc_rd_valid, nc_wr_ready, nc_wr_drop, nc_swap_pending, nc_front_bank, nc_busy_clear;
  logic [1:0] nc_mem_en, nc_mem_we, nc_dbg_state;
  logic [11:0] nc_mem_addr;

  hub75_fb_scheduler #(.CLEAR_ON_SWAP(0)) u_dut_nc (
    .clk(clk), .rst_n(nc_rst_n), .i_enable(nc_enable), .i_disp_rd_en(nc_rd_en), .i_disp_rd_addr(nc_rd_addr),
    .i_disp_frame_done(nc_frame_done), .o_disp_rd_data(nc_rd_data), .o_disp_rd_valid(nc_rd_valid),
    .i_wr_valid(nc_wr_valid), .o_wr_ready(nc_wr_ready), .i_wr_seg(nc_wr_seg), .i_wr_addr(nc_wr_addr),
    .i_wr_data(nc_wr_data), .o_wr_drop(nc_wr_drop), .i_swap_req(nc_swap_req), .o_swap_pending(nc_swap_pending),
    .o_front_bank(nc_front_bank), .o_busy_clear(nc_busy_clear), .o_mem_en(nc_mem_en), .o_mem_we(nc_mem_we),
    .o_mem_addr(nc_mem_addr), .o_mem_wdata(nc_mem_wdata), .i_mem_rdata(nc_mem_rdata), .o_dbg_state(nc_dbg_state)
  );

  // ---------------- scoreboard + reference model ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [2*PW-1:0] exp_q[$];
  logic [AW-1:0]   drop_q[$];
  logic [PW-1:0]   m_fb [2][SEGS][DEPTH];   // [bank][segment][pixel]
  logic            m_front;
  logic            m_pending;
  int              m_clr_left;               // pixels still to be zeroed
  logic            cyc_we11, cyc_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected pixel data on every read-valid, and drop events.
  initial forever begin
    @(negedge clk);
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
    if (rst_n && wr_drop) begin
      chk("wr_drop_expected", drop_q.size() != 0, 1);
      if (drop_q.size() != 0) void'(drop_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    enable = 1'b1; rd_en = 1'b0; rd_addr = '0; frame_done = 1'b0;
    wr_valid = 1'b0; wr_seg = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: checks this cycle's
  // outputs against the model, advances the model across the rising edge.
  task automatic step();
    logic in_run, exp_ready, acc, clr_now, fedge;
    logic [1:0] exp_st;
    #1;
    in_run    = !m_pending && (m_clr_left == 0);
    exp_ready = !rd_en && in_run;
    exp_st    = m_pending ? FB_SWAP_WAIT : ((m_clr_left != 0) ? FB_CLEAR : FB_RUN);
    chk("wr_ready", wr_ready, exp_ready);
    chk("swap_pending", swap_pending, m_pending);
    chk("front_bank", front_bank, m_front);
    chk("busy_clear", busy_clear, m_clr_left != 0);
    chk("dbg_state", dbg_state, exp_st);
    cyc_we11 = (mem_we == 2'b11) && (mem_wdata == '0);
    cyc_busy = busy_clear;
    acc     = wr_valid && exp_ready;
    clr_now = (m_clr_left != 0) && !rd_en;
    if (rd_en) begin
      chk("rd_mem_en", mem_en, 2'b11);
      chk("rd_mem_we", mem_we, 2'b00);
      chk("rd_mem_addr", mem_addr, {m_front, rd_addr});
      exp_q.push_back({m_fb[m_front][1][rd_addr], m_fb[m_front][0][rd_addr]});
    end else if (clr_now) begin
      chk("clr_mem_we", {mem_en, mem_we}, 4'b1111);
      chk("clr_mem_wdata", mem_wdata, 0);
      chk("clr_mem_addr", mem_addr, {!m_front, AW'(DEPTH - m_clr_left)});
    end else if (acc && int'(wr_addr) < DEPTH) begin
      chk("wr_mem_en", mem_en, wr_seg ? 2'b10 : 2'b01);
      chk("wr_mem_we", mem_we, wr_seg ? 2'b10 : 2'b01);
      chk("wr_mem_addr", mem_addr, {!m_front, wr_addr});
      chk("wr_mem_wdata", mem_wdata, wr_data);
    end else begin
      chk("idle_mem_en", {mem_en, mem_we}, 4'b0000);
    end
    if (acc) begin
      if (int'(wr_addr) < DEPTH) m_fb[!m_front][wr_seg][wr_addr] = wr_data;
      else drop_q.push_back(wr_addr);
    end
    if (clr_now) m_clr_left--;
    fedge = frame_done || !enable;
    if ((in_run && swap_req && fedge) || (m_pending && fedge)) begin
      m_front = !m_front;
      m_pending = 1'b0;
      for (int s = 0; s < SEGS; s++)
        for (int a = 0; a < DEPTH; a++) m_fb[!m_front][s][a] = '0;
      m_clr_left = DEPTH;
    end else if (in_run && swap_req) begin
      m_pending = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic settle();
    idle_inputs();
    while (m_pending || m_clr_left != 0) begin
      frame_done = m_pending;
      rd_en = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  task automatic swap_now();
    idle_inputs(); swap_req = 1'b1; frame_done = 1'b1; step(); idle_inputs();
  endtask

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, rcnt, bcnt;
    idle_inputs();
    nc_enable = 1'b1; nc_rd_en = 1'b0; nc_rd_addr = '0; nc_frame_done = 1'b0; nc_wr_valid = 1'b0;
    nc_wr_seg = 1'b0; nc_wr_addr = '0; nc_wr_data = '0; nc_swap_req = 1'b0;
    m_front = 1'b0; m_pending = 1'b0; m_clr_left = 0;
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < SEGS; s++)
        for (int a = 0; a < DEPTH; a++) m_fb[b][s][a] = '0;

    // Reset values, with requests present to exercise the gating.
    rd_en = 1'b1; wr_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_front", front_bank, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_busy", busy_clear, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_drop", wr_drop, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_mem_strobes", {mem_en, mem_we}, 0);
    chk("rst_state", dbg_state, FB_RUN);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Bring both banks to a known all-zero state using the clear itself.
    swap_now(); settle();
    swap_now(); settle();

    // Plain write, then read colliding with a write.
    wr_valid = 1'b1; wr_seg = 1'b0; wr_addr = 10'd5; wr_data = 24'h112233; step();
    rd_en = 1'b1; rd_addr = 10'd5; wr_addr = 10'd9; wr_data = 24'habcdef; step();
    rd_en = 1'b0; step();
    idle_inputs();
    // Out-of-range writes.
    wr_valid = 1'b1; wr_addr = AW'(DEPTH); wr_data = 24'h5a5a5a; step();
    wr_addr = 10'd1023; wr_seg = 1'b1; step();
    idle_inputs(); step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_addr    = AW'($urandom_range(0, DEPTH - 1));
      wr_valid   = ($urandom_range(0, 9) < 6);
      wr_seg     = 1'($urandom_range(0, 1));
      wr_addr    = AW'($urandom_range(0, 1023));
      wr_data    = PW'($urandom);
      swap_req   = ($urandom_range(0, 199) == 0);
      frame_done = ($urandom_range(0, 49) == 0);
      enable     = ($urandom_range(0, 99) != 0);
      step();
    end
    settle();

    // Swap with the display disabled happens immediately; clear length.
    enable = 1'b0; swap_req = 1'b1; step();
    idle_inputs();
    cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      step();
      if (cyc_we11) cnt++;
    end
    chk("clear_write_count", cnt, DEPTH);

    // Deferred swap, clear stretched by interleaved display reads.
    swap_req = 1'b1; step();
    swap_req = 1'b0; rd_en = 1'b1; rd_addr = 10'd77; step();
    rd_en = 1'b0; frame_done = 1'b1; step();
    frame_done = 1'b0;
    rcnt = 0; bcnt = 0;
    while (m_clr_left != 0) begin
      rd_en = ($urandom_range(0, 3) == 0);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
      if (cyc_busy) begin
        bcnt++;
        if (rd_en) rcnt++;
      end
    end
    idle_inputs(); step();
    chk("clear_stretch", bcnt, DEPTH + rcnt);

    // Reset in the middle of a clear with bank 1 in front.
    if (m_front) begin swap_now(); settle(); end
    swap_now();
    for (int i = 0; i < 100; i++) step();
    rst_n = 1'b0; wr_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midclr_rst_front", front_bank, 0);
    chk("midclr_rst_busy", busy_clear, 0);
    chk("midclr_rst_ready", wr_ready, 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    m_front = 1'b0; m_pending = 1'b0; m_clr_left = 0;
    for (int i = 0; i < 4; i++) step();

    // Default geometry, CLEAR_ON_SWAP=0.
    nc_rst_n = 1'b1;
    nc_wr_valid = 1'b1; nc_wr_seg = 1'b0; nc_wr_addr = 11'd5; nc_wr_data = 24'h112233;
    #1;
    chk("nc_t1_ready", nc_wr_ready, 1);
    chk("nc_t1_we", {nc_mem_en, nc_mem_we}, 4'b0101);
    chk("nc_t1_addr", nc_mem_addr, 12'h805);
    chk("nc_t1_wdata", nc_mem_wdata, 24'h112233);
    @(negedge clk);
    nc_wr_valid = 1'b0; nc_swap_req = 1'b1;
    @(negedge clk);
    nc_swap_req = 1'b0; nc_wr_valid = 1'b1; nc_wr_addr = 11'd7; nc_rd_en = 1'b1; nc_rd_addr = 11'd3;
    #1;
    chk("nc_pending", nc_swap_pending, 1);
    chk("nc_rd_addr", nc_mem_addr, 12'h003);
    @(negedge clk);
    nc_rd_en = 1'b0;
    #1;
    chk("nc_rd_valid", nc_rd_valid, 1);
    chk("nc_blocked_ready", nc_wr_ready, 0);
    chk("nc_blocked_we", nc_mem_we, 2'b00);
    @(negedge clk);
    nc_frame_done = 1'b1;
    #1;
    chk("nc_front_before", nc_front_bank, 0);
    @(negedge clk);
    nc_frame_done = 1'b0;
    #1;
    chk("nc_front_after", nc_front_bank, 1);
    chk("nc_pending_after", nc_swap_pending, 0);
    chk("nc_busy", nc_busy_clear, 0);
    chk("nc_ready_after", nc_wr_ready, 1);
    chk("nc_wr_addr_after", nc_mem_addr, 12'h007);
    @(negedge clk);
    nc_wr_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("drop_q_drained", drop_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
